// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-memory stall controller state encoding and
// wait-counter width.
package cpu_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// MEM-stage / data-memory bus seen by the stall controller.
// Handshake: the controller raises mem_req_o and holds mem_we_o, mem_addr_o
// and mem_wdata_o stable for as long as it waits; the memory completes the
// access by pulsing mem_ack_i for one cycle with mem_rdata_i valid in that
// same cycle. An ack seen while no request is outstanding has no effect.
interface dmem_stall_ctrl_if;

  // pipeline side
  logic        start_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [15:0] access_cnt_o;

  // data-memory side
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;

  // the stall controller itself
  modport slave (
    input  start_i, MemRead_i, MemWrite_i, addr_i, wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output stall_o, rdata_o, err_o, access_cnt_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  // the pipeline/memory environment driving the controller
  modport master (
    output start_i, MemRead_i, MemWrite_i, addr_i, wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  stall_o, rdata_o, err_o, access_cnt_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dmem_stall_ctrl.sv
// Data-memory stall controller: freezes the pipeline while a MEM-stage load
// or store waits for the data memory, with a timeout that aborts a hung
// access and leaves a sticky error flag.
module dmem_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dmem_stall_ctrl_if.slave    bus,
  output dmem_state_t         state_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       acc_q, acc_d;

  logic access;
  assign access = bus.MemRead_i | bus.MemWrite_i;

  // Next-state and registered-output logic; start_i low parks everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc_d   = acc_q;
    if (!bus.start_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            state_d = BUSY;
            cnt_d   = '0;
            // a simultaneous read+write request is a write
            we_d    = bus.MemWrite_i;
            addr_d  = bus.addr_i;
            wdata_d = bus.wdata_i;
          end
        end
        BUSY: begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // ack takes priority over a coinciding timeout
          if (bus.mem_ack_i) begin
            state_d = DONE;
            if (!we_q) rdata_d = bus.mem_rdata_i;
            if (acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
        DONE: begin
          // one free cycle for the pipeline; the still-visible request
          // belongs to the instruction that just completed
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    req_d = (state_d == BUSY);
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  // Stall is combinational so the requesting instruction freezes in its
  // first MEM cycle; gated by reset so a held reset never stalls.
  assign bus.stall_o = rst_i & (((state_q == IDLE) & bus.start_i & access) |
                                (state_q == BUSY));

  assign bus.mem_req_o    = req_q;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.err_o        = err_q;
  assign bus.access_cnt_o = acc_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Self-checking bench for dmem_stall_ctrl (instantiated with TIMEOUT=4).
module tb_dmem_stall_ctrl;
  import cpu_pkg::*;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dmem_stall_ctrl_if bus();
  dmem_state_t       state_dbg;

  dmem_stall_ctrl #(.TIMEOUT(TMO)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = '0;
  logic        model_err   = 1'b0;
  logic [15:0] model_acc   = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.MemRead_i   = 1'b0;
    bus.MemWrite_i  = 1'b0;
    bus.mem_ack_i   = 1'b0;
  endtask

  // Issue one access from an IDLE cycle and follow it to DONE.
  // ack_at = BUSY cycle (1-based) carrying the ack, 0 = never ack.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input int ack_at,
                           input logic [31:0] rd_data, input logic keep_req);
    logic        timed;
    logic [31:0] exp_r;
    int          stall_cnt;
    int          busy_k;
    bit          done;
    check("idle_entry", 32'(state_dbg), 32'(IDLE));
    bus.start_i    = 1'b1;
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.wdata_i    = d;
    bus.mem_ack_i  = 1'b0;
    #1;
    timed = (ack_at == 0) || (ack_at > TMO);
    if (timed)   exp_r = 32'h0;
    else if (wr) exp_r = model_rdata;
    else         exp_r = rd_data;
    exp_q.push_back(exp_r);
    model_rdata = exp_r;
    if (timed) model_err = 1'b1;
    else if (model_acc != 16'hFFFF) model_acc = model_acc + 16'd1;
    stall_cnt = bus.stall_o ? 1 : 0;
    check("stall_first", {31'b0, bus.stall_o}, 32'd1);
    busy_k = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (state_dbg == BUSY) begin
        busy_k++;
        check("busy_req",   {31'b0, bus.mem_req_o}, 32'd1);
        check("busy_we",    {31'b0, bus.mem_we_o}, {31'b0, wr});
        check("busy_addr",  bus.mem_addr_o, a);
        check("busy_wdata", bus.mem_wdata_o, d);
        // pipeline is frozen but upstream values may wander; capture must hold
        bus.addr_i      = $urandom;
        bus.wdata_i     = $urandom;
        bus.mem_ack_i   = (busy_k == ack_at);
        bus.mem_rdata_i = (busy_k == ack_at) ? rd_data : $urandom;
        #1;
        if (bus.stall_o) stall_cnt++;
      end else if (state_dbg == DONE) begin
        done = 1'b1;
        bus.mem_ack_i = 1'b0;
        if (!keep_req) begin
          bus.MemRead_i  = 1'b0;
          bus.MemWrite_i = 1'b0;
        end
        #1;
        if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
        else check("done_rdata", bus.rdata_o, exp_q.pop_front());
        check("done_stall", {31'b0, bus.stall_o}, 32'd0);
        check("done_req",   {31'b0, bus.mem_req_o}, 32'd0);
        check("done_err",   {31'b0, bus.err_o}, {31'b0, model_err});
        check("done_acc",   {16'b0, bus.access_cnt_o}, {16'b0, model_acc});
        check("stall_cycles", 32'(stall_cnt), 32'(1 + (timed ? TMO : ack_at)));
      end else begin
        check("fsm_path", 32'(state_dbg), 32'(BUSY));
        done = 1'b1;
      end
    end
    if (!done) check("done_reached", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   {31'b0, bus.mem_req_o}, 32'd0);
    check({tag, "_we"},    {31'b0, bus.mem_we_o}, 32'd0);
    check({tag, "_addr"},  bus.mem_addr_o, 32'd0);
    check({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
    check({tag, "_rdata"}, bus.rdata_o, 32'd0);
    check({tag, "_err"},   {31'b0, bus.err_o}, 32'd0);
    check({tag, "_acc"},   {16'b0, bus.access_cnt_o}, 32'd0);
    check({tag, "_stall"}, {31'b0, bus.stall_o}, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r;
    bus.start_i     = 1'b1;
    bus.MemRead_i   = 1'b1;   // request visible during reset must not stall
    bus.MemWrite_i  = 1'b0;
    bus.addr_i      = '0;
    bus.wdata_i     = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    #2;
    check_all_zero("reset");
    @(negedge clk_i);
    idle_inputs();
    @(negedge clk_i);
    rst_i = 1'b1;
    step();
    check("idle_after_reset", 32'(state_dbg), 32'(IDLE));
    check("idle_stall", {31'b0, bus.stall_o}, 32'd0);

    // read with ack in the 3rd BUSY cycle
    do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    step();
    // write 0x55 to 0x100; rdata keeps 0xDEADBEEF
    do_access(1'b0, 1'b1, 32'h0000_0100, 32'h0000_0055, 2, 32'hAAAA_AAAA, 1'b0);
    step();
    // ack coincides with the timeout cycle: ack wins
    do_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, TMO, 32'h1357_9BDF, 1'b0);
    step();

    // back-to-back loads with the request left asserted through DONE
    for (int i = 0; i < 3; i++) begin
      do_access(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1 + i, 32'hC0DE_0000 + 32'(i), 1'b1);
      step();
    end

    // random mix, including read+write together (treated as a write)
    for (int i = 0; i < 6; i++) begin
      int f;
      f = $urandom_range(1, 3);
      r = $urandom;
      do_access(f[0], f[1], $urandom, $urandom, $urandom_range(1, TMO), r, 1'b0);
      step();
    end

    // ack with nothing outstanding is ignored
    idle_inputs();
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 32'hFFFF_0000;
    step();
    step();
    check("stray_ack_state", 32'(state_dbg), 32'(IDLE));
    check("stray_ack_rdata", bus.rdata_o, model_rdata);
    check("stray_ack_acc",   {16'b0, bus.access_cnt_o}, {16'b0, model_acc});
    bus.mem_ack_i = 1'b0;

    // timeout: no ack
    do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    check("err_sticky", {31'b0, bus.err_o}, 32'd1);
    check("err_sticky_state", 32'(state_dbg), 32'(IDLE));

    // reset asserted mid-BUSY
    bus.MemRead_i = 1'b1;
    bus.addr_i    = 32'h0000_0400;
    step();
    check("pre_rst_busy", {31'b0, bus.mem_req_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check_all_zero("mid_rst");
    idle_inputs();
    #1;
    rst_i = 1'b1;
    model_rdata = '0;
    model_err   = 1'b0;
    model_acc   = '0;
    exp_q.delete();
    step();

    // start_i low mid-BUSY aborts without error
    do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'h1234_5678, 1'b0);
    step();
    bus.MemWrite_i = 1'b1;
    bus.addr_i     = 32'h0000_0600;
    bus.wdata_i    = 32'h0000_00AA;
    step();
    check("abort_busy", 32'(state_dbg), 32'(BUSY));
    bus.start_i = 1'b0;
    #1;
    check("abort_stall_busy", {31'b0, bus.stall_o}, 32'd1);
    step();
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    check("abort_req",   {31'b0, bus.mem_req_o}, 32'd0);
    check("abort_we",    {31'b0, bus.mem_we_o}, 32'd0);
    check("abort_addr",  bus.mem_addr_o, 32'd0);
    check("abort_wdata", bus.mem_wdata_o, 32'd0);
    check("abort_rdata", bus.rdata_o, 32'd0);
    check("abort_err",   {31'b0, bus.err_o}, 32'd0);
    check("abort_acc",   {16'b0, bus.access_cnt_o}, {16'b0, model_acc});
    step();
    check("hold_idle", 32'(state_dbg), 32'(IDLE));

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL be the maximum BUSY cycles allowed before an access is aborted (legal range 2..1023).
REQ-002 clk_i  in  1  single clock; all state SHALL update on the rising edge only.
REQ-003 rst_i  in  1  reset, SHALL be asynchronous and active-low.
REQ-004 start_i  in  1  run enable; low SHALL hold the block idle synchronously, as for pipeline registers.
REQ-005 MemRead_i / MemWrite_i  in  1 each  MEM-stage access request; both high SHALL be treated as a write.
REQ-006 addr_i / wdata_i  in  32 each  MEM-stage address and store data.
REQ-007 mem_ack_i  in  1  data-memory completion strobe; mem_rdata_i  in  32  read data, valid with the ack.
REQ-008 mem_req_o  out  1; mem_we_o  out  1; mem_addr_o  out  32; mem_wdata_o  out  32: memory request bus.
REQ-009 stall_o  out  1  freeze for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
REQ-010 rdata_o  out  32  load data for MEM/WB; err_o  out  1  sticky timeout flag; access_cnt_o  out  16  completed-access count.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 IDLE -> BUSY SHALL occur when start_i=1 and (MemRead_i or MemWrite_i); otherwise the FSM SHALL stay in IDLE.
REQ-013 On the IDLE->BUSY edge, addr_i, wdata_i and the write flag SHALL be captured into mem_addr_o, mem_wdata_o and mem_we_o, and these SHALL remain stable throughout BUSY.
REQ-014 mem_req_o SHALL be 1 exactly while in BUSY.
REQ-015 stall_o SHALL be combinational, equal to (IDLE and start_i and access) or BUSY, so the requesting instruction is frozen in MEM from its first cycle.
REQ-016 BUSY -> DONE SHALL occur on mem_ack_i=1; for a read, rdata_o SHALL capture mem_rdata_i on that edge; for a write, rdata_o SHALL be unchanged.
REQ-017 In DONE, stall_o SHALL be 0 so the pipeline advances once; DONE -> IDLE SHALL be unconditional; an access still visible in DONE SHALL NOT retrigger.
REQ-018 A 10-bit wait counter SHALL clear on BUSY entry and increment each BUSY cycle.
REQ-019 When the counter reaches TIMEOUT-1 with no ack, the FSM SHALL go BUSY -> DONE, set rdata_o=0 and set err_o=1.
REQ-020 err_o SHALL remain set until rst_i asserts.
REQ-021 If ack and timeout coincide, the ack SHALL win: the access completes normally and err_o is not set.
REQ-022 mem_ack_i while not in BUSY SHALL be ignored.
REQ-023 access_cnt_o SHALL increment on every BUSY->DONE edge caused by an ack, and SHALL saturate at 0xFFFF.
REQ-024 start_i=0 SHALL force IDLE on the next edge, zero mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o and rdata_o, and hold err_o and access_cnt_o.
REQ-025 start_i=0 mid-BUSY SHALL abort the access without setting err_o.

Reset
REQ-026 rst_i=0 SHALL asynchronously force IDLE, the counter to 0, and every registered output (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, err_o, access_cnt_o) to 0.
REQ-027 With rst_i=0, stall_o SHALL be 0.
REQ-028 Reset asserted mid-BUSY SHALL drop mem_req_o immediately, without waiting for a clock edge.
REQ-029 Deassertion of rst_i SHALL be treated as synchronous to clk_i by the integrator.

Structure
REQ-030 The state encoding (2-bit enum IDLE=0, BUSY=1, DONE=2) and CNT_W=10 SHALL live in the shared cpu_pkg package.
REQ-031 The block SHALL be a single module with no sub-modules; the saturating counter SHALL be inline.
REQ-032 The block SHALL be instantiated once in CPU, between EX_MEM and the data memory, with stall_o fanned out to all pipeline registers.

Verification
REQ-033 Read, ack after 3 BUSY cycles, rdata 0xDEADBEEF: stall_o=1 for 4 cycles, then rdata_o=0xDEADBEEF in DONE with stall_o=0, and access_cnt_o=1.
REQ-034 Write to addr 0x100, data 0x55: mem_we_o=1, mem_addr_o=0x100 and mem_wdata_o=0x55 stable through BUSY; rdata_o unchanged after ack.
REQ-035 TIMEOUT=4, no ack: DONE after 4 BUSY cycles with rdata_o=0 and err_o=1; err_o still 1 after 10 further idle cycles.
REQ-036 TIMEOUT=4, ack on the 4th BUSY cycle: normal completion with err_o=0.
REQ-037 Back-to-back loads every cycle: each load sees IDLE, BUSY, DONE with exactly one non-stall DONE cycle, and no retrigger in DONE.
REQ-038 rst_i low mid-BUSY: mem_req_o=0 before the next edge and all outputs 0; start_i low mid-BUSY: IDLE next edge with err_o=0.
